pipe_hazard_ctrl: RTL and testbench

Central hazard and flush scheduler for the five-stage pipeline (fetch, decode/reg-read, execute, mem, write_back). It keeps a scoreboard of in-flight register and CPSR writes, decides each cycle whether decode may issue into execute, and sequences the stall and flush signals that fetch, decode and execute currently generate locally. It sits beside the pipeline, takes issue information from decode, branch information from execute, and retire information from write_back.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush scheduler for the five-stage pipeline: tracks in-flight register and CPSR
// writes, gates decode-to-execute issue, and sequences the fetch/decode stalls and flushes.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS     = 16,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_valid_i,
  input  logic                        issue_r1_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] issue_r1_i,
  input  logic                        issue_r2_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] issue_r2_i,
  input  logic                        issue_rd_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd_i,
  input  logic                        issue_flags_rd_i,
  input  logic                        issue_flags_wr_i,
  input  logic                        retire_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] retire_addr_i,
  input  logic                        flags_retire_i,
  input  logic                        branch_i,
  input  logic                        pc_wb_i,
  output logic                        issue_o,
  output logic                        stall_fetch_o,
  output logic                        stall_decode_o,
  output logic                        flush_fetch_o,
  output logic                        flush_decode_o,
  output logic [NUM_REGS-1:0]         pending_o,
  output logic [1:0]                  state_o,
  output logic                        error_o
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [FW-1:0]    FLUSH_INIT = FW'(FLUSH_CYCLES);
  localparam logic [AW-1:0]    PC_ADDR    = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [FW-1:0]    fcnt_reg, fcnt_next;
  logic [CNT_W-1:0] cnt_reg [NUM_REGS];
  logic [CNT_W-1:0] flag_cnt_reg;
  logic             error_reg, error_next;

  logic src_hazard, flag_hazard, sat_hazard;
  logic flag_inc, flag_dec;

  // Hazards look only at registered counters, so a retire unblocks its dependant one cycle later.
  assign src_hazard  = (issue_r1_en_i && cnt_reg[issue_r1_i] != '0) ||
                       (issue_r2_en_i && cnt_reg[issue_r2_i] != '0);
  assign flag_hazard = issue_flags_rd_i && flag_cnt_reg != '0;
  assign sat_hazard  = (issue_rd_en_i && cnt_reg[issue_rd_i] == CNT_MAX) ||
                       (issue_flags_wr_i && flag_cnt_reg == CNT_MAX);

  assign issue_o = ~reset_i & issue_valid_i & (state_reg == RUN) & ~branch_i &
                   ~src_hazard & ~flag_hazard & ~sat_hazard;
  assign stall_fetch_o  = ~reset_i & issue_valid_i & ~issue_o & (state_reg != FLUSH);
  assign stall_decode_o = stall_fetch_o;
  assign flush_fetch_o  = (state_reg == FLUSH);
  assign flush_decode_o = (state_reg == FLUSH);
  assign state_o        = state_reg;
  assign error_o        = error_reg;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      logic inc, dec;
      assign inc = issue_o && issue_rd_en_i && issue_rd_i == AW'(gi);
      assign dec = retire_en_i && retire_addr_i == AW'(gi) && cnt_reg[gi] != '0;
      assign pending_o[gi] = |cnt_reg[gi];

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)          cnt_reg[gi] <= '0;
        else if (inc && !dec) cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        else if (dec && !inc) cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
      end
    end
  endgenerate

  assign flag_inc = issue_o && issue_flags_wr_i;
  assign flag_dec = flags_retire_i && flag_cnt_reg != '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                    flag_cnt_reg <= '0;
    else if (flag_inc && !flag_dec) flag_cnt_reg <= flag_cnt_reg + 1'b1;
    else if (flag_dec && !flag_inc) flag_cnt_reg <= flag_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= RUN;
      fcnt_reg  <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    error_next = error_reg;
    // Protocol violations: retiring an idle counter, or redirects arriving in the wrong state.
    if (retire_en_i && cnt_reg[retire_addr_i] == '0) error_next = 1'b1;
    if (flags_retire_i && flag_cnt_reg == '0)       error_next = 1'b1;
    if (branch_i && state_reg != RUN)               error_next = 1'b1;
    if (pc_wb_i && state_reg != WAIT_PC)            error_next = 1'b1;
    case (state_reg)
      RUN: begin
        if (branch_i) begin
          state_next = FLUSH;
          fcnt_next  = FLUSH_INIT;
        end else if (issue_o && issue_rd_en_i && issue_rd_i == PC_ADDR) begin
          state_next = WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (pc_wb_i) begin
          state_next = FLUSH;
          fcnt_next  = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (fcnt_reg <= FW'(1)) begin
          state_next = RUN;
          fcnt_next  = '0;
        end else begin
          fcnt_next = fcnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = RUN;
        fcnt_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic, all
// compared each cycle against a cycle-indexed scoreboard model.
module tb_pipe_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CMAX = 3;
  localparam int M_RUN = 0, M_FLUSH = 1, M_WAIT = 2;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic v, r1e, r2e, rde, frd, fwr, re, fret, br, pcw;
  logic [3:0] r1, r2, rd, ra;
  logic issue_o, stall_fetch_o, stall_decode_o, flush_fetch_o, flush_decode_o, error_o;
  logic [15:0] pending_o;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  // Reference model: pending-write counts, mode, flush end cycle, sticky error.
  int cnt [16];
  int fc;
  int mode;
  int cyc;
  int flush_until;
  bit m_err;

  pipe_hazard_ctrl #(.NUM_REGS(16), .CNT_W(2), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_valid_i(v), .issue_r1_en_i(r1e), .issue_r1_i(r1),
    .issue_r2_en_i(r2e), .issue_r2_i(r2), .issue_rd_en_i(rde), .issue_rd_i(rd),
    .issue_flags_rd_i(frd), .issue_flags_wr_i(fwr),
    .retire_en_i(re), .retire_addr_i(ra), .flags_retire_i(fret),
    .branch_i(br), .pc_wb_i(pcw),
    .issue_o(issue_o), .stall_fetch_o(stall_fetch_o), .stall_decode_o(stall_decode_o),
    .flush_fetch_o(flush_fetch_o), .flush_decode_o(flush_decode_o),
    .pending_o(pending_o), .state_o(state_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    v = 0; r1e = 0; r2e = 0; rde = 0; frd = 0; fwr = 0; re = 0; fret = 0; br = 0; pcw = 0;
    r1 = 0; r2 = 0; rd = 0; ra = 0;
  endtask

  task automatic model_clear();
    foreach (cnt[i]) cnt[i] = 0;
    fc = 0; mode = M_RUN; m_err = 0; flush_until = -1;
  endtask

  function automatic bit model_issue();
    if (!v || mode != M_RUN || br) return 0;
    if (r1e && cnt[r1] > 0) return 0;
    if (r2e && cnt[r2] > 0) return 0;
    if (frd && fc > 0) return 0;
    if (rde && cnt[rd] == CMAX) return 0;
    if (fwr && fc == CMAX) return 0;
    return 1;
  endfunction

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = (cnt[i] > 0);
    return p;
  endfunction

  // One clock cycle: inputs already driven; check outputs late in the cycle, then advance model.
  task automatic tick();
    bit ei, es;
    ei = model_issue();
    es = v && !ei && mode != M_FLUSH;
    #3;
    chk("issue", issue_o, ei);
    chk("stall_fetch", stall_fetch_o, es);
    chk("stall_decode", stall_decode_o, es);
    chk("flush_fetch", flush_fetch_o, mode == M_FLUSH);
    chk("flush_decode", flush_decode_o, mode == M_FLUSH);
    chk("pending", pending_o, model_pending());
    chk("state", state_o, mode);
    chk("error", error_o, m_err);
    @(posedge clk_i);
    if (re) begin
      if (cnt[ra] == 0) m_err = 1; else cnt[ra]--;
    end
    if (fret) begin
      if (fc == 0) m_err = 1; else fc--;
    end
    if (ei && rde) cnt[rd]++;
    if (ei && fwr) fc++;
    case (mode)
      M_RUN: begin
        if (pcw) m_err = 1;
        if (br) begin mode = M_FLUSH; flush_until = cyc + FLUSH_CYCLES; end
        else if (ei && rde && rd == 4'd15) mode = M_WAIT;
      end
      M_WAIT: begin
        if (br) m_err = 1;
        if (pcw) begin mode = M_FLUSH; flush_until = cyc + FLUSH_CYCLES; end
      end
      default: begin
        if (br || pcw) m_err = 1;
        if (cyc == flush_until) mode = M_RUN;
      end
    endcase
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1;
    v = 1; r1e = 0; r2e = 0; rde = 1; rd = 4'd6;
    #1;
    chk("rst_issue", issue_o, 0);
    chk("rst_stall", stall_fetch_o | stall_decode_o, 0);
    chk("rst_flush", flush_fetch_o | flush_decode_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_error", error_o, 0);
    @(posedge clk_i);
    #1;
    reset_i = 0;
    model_clear();
    idle();
  endtask

  task automatic issue_rd(input logic [3:0] d);
    idle(); v = 1; rde = 1; rd = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    idle();
    model_clear();
    reset_i = 1;
    @(posedge clk_i); #1;
    reset_i = 0;
    idle(); tick();

    // RAW: write r4, dependant stalls until retire of r4, issues the next cycle.
    issue_rd(4); tick();
    idle(); v = 1; r1e = 1; r1 = 4; tick(); tick();
    re = 1; ra = 4; tick();
    re = 0; tick();
    chk("raw_pending4", pending_o[4], 0);

    // Issue and retire of r5 in the same cycle keep the count at one.
    issue_rd(5); tick();
    issue_rd(5); re = 1; ra = 5; tick();
    chk("simul_pending5", pending_o[5], 1);
    idle(); re = 1; ra = 5; tick();
    chk("simul_cleared5", pending_o[5], 0);

    // Saturation on r2, then an underflowing retire raises error.
    for (int i = 0; i < 4; i++) begin issue_rd(2); tick(); end
    for (int i = 0; i < 3; i++) begin idle(); re = 1; ra = 2; tick(); end
    idle(); re = 1; ra = 2; tick();
    idle(); tick();
    chk("underflow_error", error_o, 1);

    // Branch squashes the concurrent issue, two flush cycles, then RUN.
    issue_rd(7); br = 1; tick();
    idle(); v = 1; tick(); tick(); tick();
    chk("branch_run", state_o, M_RUN);

    // Reset in the middle of a flush with r3 pending twice.
    issue_rd(3); tick(); tick();
    idle(); br = 1; tick();
    idle(); tick();
    do_reset();
    idle(); tick();

    // R15 write: blocked in WAIT_PC until pc write-back, then flush.
    issue_rd(15); tick();
    idle(); v = 1; tick(); tick(); tick();
    idle(); v = 1; pcw = 1; re = 1; ra = 15; tick();
    idle(); v = 1; tick(); tick(); tick();

    // CMP then conditional: stalls until the flag update retires.
    idle(); v = 1; fwr = 1; tick();
    idle(); v = 1; frd = 1; tick(); tick();
    fret = 1; tick();
    fret = 0; tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      idle();
      v   = ($urandom_range(0, 9) < 7);
      r1e = $urandom_range(0, 1); r1 = 4'($urandom_range(0, 7));
      r2e = $urandom_range(0, 1); r2 = 4'($urandom_range(0, 7));
      rde = $urandom_range(0, 1);
      rd  = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      frd = ($urandom_range(0, 3) == 0);
      fwr = ($urandom_range(0, 3) == 0);
      ra  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      re  = (cnt[ra] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      fret = (fc > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      br  = ($urandom_range(0, 24) == 0);
      pcw = (mode == M_WAIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
